laser_bank: RTL and testbench

Multi-shot player laser pool for the space-invaders datapath. It holds up to NUM_SHOTS independent lasers, spawns one at the gun on `fire` subject to a cooldown, and moves every live shot upward one step per motion tick. It retires shots on alien hits or when they leave the top of the screen, and it produces the laser pixel colour for the VGA mixer. It sits between the player/gun logic, the alien collision block and the colour mux.

---
 rtl/laser_bank_if.sv | 26 ++
 rtl/laser_bank.sv | 141 ++++++++++++++
 tb/tb_laser_bank.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/laser_bank_if.sv
// Bus bundle between the laser pool and its neighbours: gun/collision/VGA
// inputs, plus the per-slot positions and the laser pixel colour.
interface laser_bank_if #(
    parameter int NUM_SHOTS = 4
);
    logic                      enable;
    logic                      fire;
    logic [NUM_SHOTS-1:0]      hitMask;
    logic [9:0]                gunPosition;
    logic [9:0]                hPos;
    logic [9:0]                vPos;
    logic [10*NUM_SHOTS-1:0]   xLasers;
    logic [10*NUM_SHOTS-1:0]   yLasers;
    logic [NUM_SHOTS-1:0]      aliveMask;
    logic [2:0]                colorLaser;

    modport master (
        output enable, fire, hitMask, gunPosition, hPos, vPos,
        input  xLasers, yLasers, aliveMask, colorLaser
    );

    modport slave (
        input  enable, fire, hitMask, gunPosition, hPos, vPos,
        output xLasers, yLasers, aliveMask, colorLaser
    );
endinterface

// File: rtl/laser_bank.sv
// Multi-shot player laser pool: spawns lasers at the gun under a cooldown,
// moves them up once per motion tick, retires them and draws their pixels.
module laser_bank #(
    parameter int NUM_SHOTS     = 4,
    parameter int RADIUS        = 4,
    parameter int STEP_MOTION   = 1,
    parameter int COOLDOWN      = 30,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int SHIP_HEIGHT   = 30,
    parameter int V_OFFSET      = 10,
    parameter logic [2:0] LASER      = 3'd6,
    parameter logic [2:0] BACKGROUND = 3'd0
) (
    input  logic         clk,
    input  logic         reset,
    laser_bank_if.slave  bus
);
    localparam int          CW        = $clog2(COOLDOWN + 1);
    localparam logic [9:0]  SPAWN_Y   = 10'(SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT - RADIUS);
    localparam logic [9:0]  PARK_X    = 10'(SCREEN_WIDTH - 1);
    localparam logic [9:0]  PARK_Y    = 10'(SCREEN_HEIGHT - 1);
    localparam logic [9:0]  STEP      = 10'(STEP_MOTION);
    localparam logic [21:0] RAD_SQ    = 22'(RADIUS * RADIUS);
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN);

    logic [NUM_SHOTS-1:0]        alive_r;
    logic [NUM_SHOTS-1:0]        pendingKill_r;
    logic [NUM_SHOTS-1:0][9:0]   xPos_r;
    logic [NUM_SHOTS-1:0][9:0]   yPos_r;
    logic [CW-1:0]               cooldown_r;
    logic [2:0]                  colorLaser_r;

    logic [NUM_SHOTS-1:0]        aliveNext_s;
    logic [NUM_SHOTS-1:0]        pendingNext_s;
    logic [NUM_SHOTS-1:0][9:0]   xNext_s;
    logic [NUM_SHOTS-1:0][9:0]   yNext_s;
    logic [CW-1:0]               cooldownNext_s;
    logic [2:0]                  colorNext_s;
    logic                        fireOk_s;
    logic                        spawnFound_s;
    logic [NUM_SHOTS-1:0]        inRange_s;

    // Slot movement, retirement, spawn selection and cooldown bookkeeping.
    always_comb begin
        aliveNext_s    = alive_r;
        xNext_s        = xPos_r;
        yNext_s        = yPos_r;
        cooldownNext_s = cooldown_r;
        pendingNext_s  = pendingKill_r | (bus.hitMask & alive_r);
        spawnFound_s   = 1'b0;
        // Free slots are judged on state at the start of the tick, so a
        // slot retiring on this tick is never handed out again immediately.
        fireOk_s       = bus.enable && bus.fire && (cooldown_r == {CW{1'b0}})
                         && (~alive_r != {NUM_SHOTS{1'b0}});
        if (bus.enable) begin
            pendingNext_s = {NUM_SHOTS{1'b0}};
            for (int i = 0; i < NUM_SHOTS; i++) begin
                if (alive_r[i]) begin
                    if (pendingKill_r[i] || bus.hitMask[i]) begin
                        aliveNext_s[i] = 1'b0;
                        xNext_s[i]     = PARK_X;
                        yNext_s[i]     = PARK_Y;
                    end else if (yPos_r[i] >= STEP) begin
                        yNext_s[i]     = yPos_r[i] - STEP;
                    end else begin
                        aliveNext_s[i] = 1'b0;
                        xNext_s[i]     = PARK_X;
                        yNext_s[i]     = PARK_Y;
                    end
                end else if (fireOk_s && !spawnFound_s) begin
                    aliveNext_s[i] = 1'b1;
                    xNext_s[i]     = bus.gunPosition;
                    yNext_s[i]     = SPAWN_Y;
                    spawnFound_s   = 1'b1;
                end else begin
                    spawnFound_s   = spawnFound_s;
                end
            end
            if (fireOk_s) begin
                cooldownNext_s = COOL_LOAD;
            end else if (cooldown_r != {CW{1'b0}}) begin
                cooldownNext_s = cooldown_r - CW'(1);
            end else begin
                cooldownNext_s = cooldown_r;
            end
        end else begin
            cooldownNext_s = cooldown_r;
        end
    end

    // Per-slot disc test; widened to 22 bits so the squared distance of any
    // on-screen offset fits without wrapping.
    for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
        logic [10:0] dx_s;
        logic [10:0] dy_s;
        logic [21:0] dxWide_s;
        logic [21:0] dyWide_s;
        logic [21:0] distSq_s;
        assign dx_s         = {1'b0, bus.hPos} - {1'b0, xPos_r[g]};
        assign dy_s         = {1'b0, bus.vPos} - {1'b0, yPos_r[g]};
        assign dxWide_s     = {{11{dx_s[10]}}, dx_s};
        assign dyWide_s     = {{11{dy_s[10]}}, dy_s};
        assign distSq_s     = (dxWide_s * dxWide_s) + (dyWide_s * dyWide_s);
        assign inRange_s[g] = alive_r[g] && (distSq_s <= RAD_SQ);
    end

    // Pixel colour selection for the mixer.
    always_comb begin
        colorNext_s = BACKGROUND;
        if (inRange_s != {NUM_SHOTS{1'b0}}) begin
            colorNext_s = LASER;
        end else begin
            colorNext_s = BACKGROUND;
        end
    end

    // State register with synchronous reset parking every slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            alive_r       <= {NUM_SHOTS{1'b0}};
            pendingKill_r <= {NUM_SHOTS{1'b0}};
            xPos_r        <= {NUM_SHOTS{PARK_X}};
            yPos_r        <= {NUM_SHOTS{PARK_Y}};
            cooldown_r    <= {CW{1'b0}};
            colorLaser_r  <= BACKGROUND;
        end else begin
            alive_r       <= aliveNext_s;
            pendingKill_r <= pendingNext_s;
            xPos_r        <= xNext_s;
            yPos_r        <= yNext_s;
            cooldown_r    <= cooldownNext_s;
            colorLaser_r  <= colorNext_s;
        end
    end

    assign bus.xLasers    = xPos_r;
    assign bus.yLasers    = yPos_r;
    assign bus.aliveMask  = alive_r;
    assign bus.colorLaser = colorLaser_r;
endmodule

// File: tb/tb_laser_bank.sv
// Self-checking bench for laser_bank: directed scenarios plus a randomized
// run against a slot-level behavioural model of the laser pool.
module tb_laser_bank;
    localparam int NS      = 4;
    localparam int SPAWN   = 436;
    localparam int PX      = 639;
    localparam int PY      = 479;
    localparam int COOL    = 30;

    logic clk = 1'b0;
    logic reset = 1'b1;
    laser_bank_if #(.NUM_SHOTS(NS)) bus();

    laser_bank dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int mAlive[NS];
    int mX[NS];
    int mY[NS];
    int mPend[NS];
    int mCool;
    logic [2:0] expColor;

    function automatic logic [10*NS-1:0] packX();
        logic [10*NS-1:0] v;
        for (int i = 0; i < NS; i++) v[10*i +: 10] = 10'(mX[i]);
        return v;
    endfunction

    function automatic logic [10*NS-1:0] packY();
        logic [10*NS-1:0] v;
        for (int i = 0; i < NS; i++) v[10*i +: 10] = 10'(mY[i]);
        return v;
    endfunction

    function automatic logic [NS-1:0] packAlive();
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i] = (mAlive[i] != 0);
        return v;
    endfunction

    // One clock: apply inputs, advance the model, land just after the edge.
    task automatic drive(input logic r, input logic en, input logic fr,
                         input logic [NS-1:0] hit, input int gun, input int h, input int v);
        int was[NS];
        int taken;
        logic [2:0] nc;
        h = h & 1023;
        v = v & 1023;
        @(negedge clk);
        reset = r;
        bus.enable = en;
        bus.fire = fr;
        bus.hitMask = hit;
        bus.gunPosition = 10'(gun);
        bus.hPos = 10'(h);
        bus.vPos = 10'(v);
        nc = 3'd0;
        if (!r) begin
            for (int i = 0; i < NS; i++)
                if (mAlive[i] != 0 && ((h - mX[i]) * (h - mX[i]) + (v - mY[i]) * (v - mY[i])) <= 16)
                    nc = 3'd6;
        end
        if (r) begin
            for (int i = 0; i < NS; i++) begin
                mAlive[i] = 0; mX[i] = PX; mY[i] = PY; mPend[i] = 0;
            end
            mCool = 0;
        end else if (en) begin
            for (int i = 0; i < NS; i++) was[i] = mAlive[i];
            for (int i = 0; i < NS; i++) begin
                if (was[i] != 0) begin
                    if (mPend[i] != 0 || hit[i]) begin
                        mAlive[i] = 0; mX[i] = PX; mY[i] = PY;
                    end else if (mY[i] >= 1) begin
                        mY[i] = mY[i] - 1;
                    end else begin
                        mAlive[i] = 0; mX[i] = PX; mY[i] = PY;
                    end
                end
                mPend[i] = 0;
            end
            taken = 0;
            if (fr && mCool == 0) begin
                for (int i = 0; i < NS; i++) begin
                    if (was[i] == 0 && taken == 0) begin
                        mAlive[i] = 1; mX[i] = gun & 1023; mY[i] = SPAWN; taken = 1;
                    end
                end
            end
            if (taken != 0) mCool = COOL;
            else if (mCool > 0) mCool = mCool - 1;
        end else begin
            for (int i = 0; i < NS; i++)
                if (hit[i] && mAlive[i] != 0) mPend[i] = 1;
        end
        @(posedge clk);
        #1;
        expColor = nc;
    endtask

    task automatic tick(input logic fr, input int gun);
        drive(1'b0, 1'b1, fr, '0, gun, 0, 0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, '0, gun, 0, 0);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, '0, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b1, 4'hF, 0, 639, 479);
        checks++;
        if (bus.aliveMask !== 4'b0000) begin
            failures++; $display("FAIL reset_alive got=%b want=0000", bus.aliveMask);
        end
        checks++;
        if (bus.xLasers !== {NS{10'd639}} || bus.yLasers !== {NS{10'd479}}) begin
            failures++; $display("FAIL reset_park got x=%h y=%h", bus.xLasers, bus.yLasers);
        end
        checks++;
        if (bus.colorLaser !== 3'd0) begin
            failures++; $display("FAIL reset_color got=%0d want=0", bus.colorLaser);
        end
    endtask

    task automatic test_fire_move();
        drive(1'b1, 1'b0, 1'b0, '0, 0, 0, 0);
        tick(1'b1, 100);
        checks++;
        if (bus.aliveMask !== 4'b0001 || bus.xLasers[9:0] !== 10'd100 || bus.yLasers[9:0] !== 10'd436) begin
            failures++;
            $display("FAIL fire_spawn got alive=%b x=%0d y=%0d want 0001 100 436",
                     bus.aliveMask, bus.xLasers[9:0], bus.yLasers[9:0]);
        end
        for (int k = 0; k < 10; k++) tick(1'b0, 100);
        checks++;
        if (bus.yLasers[9:0] !== 10'd426) begin
            failures++; $display("FAIL move_ten got=%0d want=426", bus.yLasers[9:0]);
        end
        for (int k = 0; k < 20; k++) tick(1'b1, 50);
        checks++;
        if (bus.aliveMask !== 4'b0001) begin
            failures++; $display("FAIL cooldown_block got=%b want=0001", bus.aliveMask);
        end
        tick(1'b1, 50);
        checks++;
        if (bus.aliveMask !== 4'b0011 || bus.xLasers[19:10] !== 10'd50 || bus.yLasers[19:10] !== 10'd436) begin
            failures++;
            $display("FAIL cooldown_expire got alive=%b x1=%0d y1=%0d want 0011 50 436",
                     bus.aliveMask, bus.xLasers[19:10], bus.yLasers[19:10]);
        end
    endtask

    task automatic test_fire_rate();
        logic [3:0] want;
        drive(1'b1, 1'b0, 1'b0, '0, 0, 0, 0);
        for (int k = 0; k <= 124; k++) begin
            tick(1'b1, 100 + k);
            want = (k >= 93) ? 4'b1111 : (k >= 62) ? 4'b0111 : (k >= 31) ? 4'b0011 : 4'b0001;
            checks++;
            if (bus.aliveMask !== want) begin
                failures++; $display("FAIL fire_rate tick=%0d got=%b want=%b", k, bus.aliveMask, want);
            end
        end
        checks++;
        if (bus.yLasers[9:0] !== 10'd312 || bus.xLasers[39:30] !== 10'd193) begin
            failures++;
            $display("FAIL fire_rate_pos got y0=%0d x3=%0d want 312 193", bus.yLasers[9:0], bus.xLasers[39:30]);
        end
    endtask

    task automatic test_hit();
        logic [9:0] y0;
        logic [9:0] y1;
        logic [9:0] y3;
        y0 = bus.yLasers[9:0];
        y1 = bus.yLasers[19:10];
        drive(1'b0, 1'b0, 1'b0, 4'b0010, 0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 0, 0, 0);
        checks++;
        if (bus.aliveMask !== 4'b1111 || bus.yLasers[19:10] !== y1) begin
            failures++;
            $display("FAIL hit_pending got alive=%b y1=%0d want 1111 %0d", bus.aliveMask, bus.yLasers[19:10], y1);
        end
        tick(1'b0, 0);
        checks++;
        if (bus.aliveMask !== 4'b1101 || bus.xLasers[19:10] !== 10'd639 || bus.yLasers[19:10] !== 10'd479) begin
            failures++;
            $display("FAIL hit_retire got alive=%b x1=%0d y1=%0d want 1101 639 479",
                     bus.aliveMask, bus.xLasers[19:10], bus.yLasers[19:10]);
        end
        checks++;
        if (bus.yLasers[9:0] !== y0 - 10'd1) begin
            failures++; $display("FAIL hit_others_move got=%0d want=%0d", bus.yLasers[9:0], y0 - 10'd1);
        end
        y3 = bus.yLasers[39:30];
        drive(1'b0, 1'b1, 1'b0, 4'b0100, 0, 0, 0);
        checks++;
        if (bus.aliveMask !== 4'b1001 || bus.yLasers[39:30] !== y3 - 10'd1) begin
            failures++;
            $display("FAIL hit_on_enable got alive=%b y3=%0d want 1001 %0d", bus.aliveMask, bus.yLasers[39:30], y3 - 10'd1);
        end
    endtask

    task automatic test_off_screen();
        drive(1'b1, 1'b0, 1'b0, '0, 0, 0, 0);
        for (int k = 0; k <= 436; k++) tick(k <= 93, 300);
        checks++;
        if (bus.yLasers[9:0] !== 10'd0 || bus.aliveMask !== 4'b1111) begin
            failures++; $display("FAIL top_reach got y0=%0d alive=%b want 0 1111", bus.yLasers[9:0], bus.aliveMask);
        end
        tick(1'b1, 400);
        checks++;
        if (bus.aliveMask !== 4'b1110 || bus.yLasers[9:0] !== 10'd479) begin
            failures++; $display("FAIL top_die_reject got alive=%b y0=%0d want 1110 479", bus.aliveMask, bus.yLasers[9:0]);
        end
        tick(1'b1, 77);
        checks++;
        if (bus.aliveMask !== 4'b1111 || bus.xLasers[9:0] !== 10'd77 || bus.yLasers[9:0] !== 10'd436) begin
            failures++;
            $display("FAIL top_reuse got alive=%b x0=%0d y0=%0d want 1111 77 436",
                     bus.aliveMask, bus.xLasers[9:0], bus.yLasers[9:0]);
        end
    endtask

    task automatic test_color();
        drive(1'b1, 1'b0, 1'b0, '0, 0, 0, 0);
        tick(1'b1, 200);
        for (int k = 0; k < 136; k++) tick(1'b0, 200);
        checks++;
        if (bus.xLasers[9:0] !== 10'd200 || bus.yLasers[9:0] !== 10'd300) begin
            failures++; $display("FAIL color_setup got x=%0d y=%0d want 200 300", bus.xLasers[9:0], bus.yLasers[9:0]);
        end
        drive(1'b0, 1'b0, 1'b0, '0, 0, 204, 300);
        checks++;
        if (bus.colorLaser !== 3'd6) begin
            failures++; $display("FAIL color_edge got=%0d want=6", bus.colorLaser);
        end
        drive(1'b0, 1'b0, 1'b0, '0, 0, 196, 300);
        checks++;
        if (bus.colorLaser !== 3'd6) begin
            failures++; $display("FAIL color_left got=%0d want=6", bus.colorLaser);
        end
        drive(1'b0, 1'b0, 1'b0, '0, 0, 202, 303);
        checks++;
        if (bus.colorLaser !== 3'd6) begin
            failures++; $display("FAIL color_diag got=%0d want=6", bus.colorLaser);
        end
        drive(1'b0, 1'b0, 1'b0, '0, 0, 203, 303);
        checks++;
        if (bus.colorLaser !== expColor) begin
            failures++; $display("FAIL color_corner got=%0d want=%0d", bus.colorLaser, expColor);
        end
        drive(1'b0, 1'b0, 1'b0, '0, 0, 205, 300);
        checks++;
        if (bus.colorLaser !== 3'd0) begin
            failures++; $display("FAIL color_outside got=%0d want=0", bus.colorLaser);
        end
        drive(1'b0, 1'b1, 1'b0, 4'b0001, 0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, '0, 0, 204, 300);
        checks++;
        if (bus.colorLaser !== 3'd0) begin
            failures++; $display("FAIL color_dead got=%0d want=0", bus.colorLaser);
        end
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 1'b0, 1'b0, '0, 0, 0, 0);
        for (int k = 0; k <= 62; k++) tick(1'b1, 100);
        for (int k = 0; k < 18; k++) tick(1'b0, 100);
        checks++;
        if (bus.aliveMask !== 4'b0111) begin
            failures++; $display("FAIL midflight_setup got=%b want=0111", bus.aliveMask);
        end
        drive(1'b1, 1'b1, 1'b1, 4'b1111, 100, 100, 356);
        checks++;
        if (bus.aliveMask !== 4'b0000 || bus.xLasers !== {NS{10'd639}} || bus.yLasers !== {NS{10'd479}}) begin
            failures++;
            $display("FAIL midflight_park got alive=%b x=%h y=%h", bus.aliveMask, bus.xLasers, bus.yLasers);
        end
        checks++;
        if (bus.colorLaser !== 3'd0) begin
            failures++; $display("FAIL midflight_color got=%0d want=0", bus.colorLaser);
        end
        tick(1'b1, 55);
        checks++;
        if (bus.aliveMask !== 4'b0001 || bus.xLasers[9:0] !== 10'd55) begin
            failures++; $display("FAIL midflight_cool got alive=%b x0=%0d want 0001 55", bus.aliveMask, bus.xLasers[9:0]);
        end
    endtask

    task automatic test_random();
        logic en;
        logic fr;
        logic r;
        logic [NS-1:0] hit;
        int gun;
        int h;
        int v;
        int j;
        drive(1'b1, 1'b0, 1'b0, '0, 0, 0, 0);
        for (int c = 0; c < 4000; c++) begin
            r   = ($urandom_range(0, 599) == 0);
            en  = ($urandom_range(0, 3) == 0);
            fr  = 1'($urandom_range(0, 1));
            hit = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
            gun = $urandom_range(0, 639);
            j   = $urandom_range(0, NS - 1);
            if ($urandom_range(0, 1) == 1) begin
                h = mX[j] + $urandom_range(0, 10) - 5;
                v = mY[j] + $urandom_range(0, 10) - 5;
            end else begin
                h = $urandom_range(0, 1023);
                v = $urandom_range(0, 1023);
            end
            drive(r, en, fr, hit, gun, h, v);
            checks++;
            if (bus.aliveMask !== packAlive() || bus.xLasers !== packX() || bus.yLasers !== packY()) begin
                failures++;
                $display("FAIL rand_state cyc=%0d got alive=%b x=%h y=%h want alive=%b x=%h y=%h",
                         c, bus.aliveMask, bus.xLasers, bus.yLasers, packAlive(), packX(), packY());
            end
            checks++;
            if (bus.colorLaser !== expColor) begin
                failures++; $display("FAIL rand_color cyc=%0d got=%0d want=%0d", c, bus.colorLaser, expColor);
            end
        end
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.fire = 1'b0;
        bus.hitMask = '0;
        bus.gunPosition = '0;
        bus.hPos = '0;
        bus.vPos = '0;
        for (int i = 0; i < NS; i++) begin
            mAlive[i] = 0; mX[i] = PX; mY[i] = PY; mPend[i] = 0;
        end
        mCool = 0;
        expColor = 3'd0;
        test_reset();
        test_fire_move();
        test_fire_rate();
        test_hit();
        test_off_screen();
        test_color();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
